a2d_spi_resp: RTL

A2D_SPI_RESP -- requirements
Module: a2d_spi_resp

---
 rtl/a2d_pkg.sv | 13 +
 rtl/spi_sync_edge.sv | 20 ++
 rtl/a2d_spi_resp.sv | 121 ++++++++++++
 3 files changed

// File: rtl/a2d_pkg.sv
// Shared definitions for the A2D SPI responder and the matching SPI master.
package a2d_pkg;
  localparam int FRAME_BITS = 16;
  localparam int CHNL_W     = 3;
  localparam int VAL_W      = 12;
  localparam int NUM_CHNL   = 8;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    FULL  = 2'd2
  } a2d_state_e;
endpackage

// File: rtl/spi_sync_edge.sv
// 3-flop synchronizer for a slow asynchronous SPI line with edge pulses.
module spi_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_async,
  output logic o_rise,
  output logic o_fall
);
  logic [2:0] r_sync;

  // Shift the line through three flops; idle-high lines reset to 1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_sync <= 3'b111;
    else        r_sync <= {r_sync[1:0], i_async};
  end

  // Stage 3 is the previous value of stage 2.
  assign o_rise = ~r_sync[2] &  r_sync[1];
  assign o_fall =  r_sync[2] & ~r_sync[1];
endmodule

// File: rtl/a2d_spi_resp.sv
// SPI slave (SCLK idle high) that accepts 16-bit channel commands and
// returns the channel addressed by the previous accepted command.
module a2d_spi_resp
  import a2d_pkg::*;
(
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        SS_n,
  input  logic                        SCLK,
  input  logic                        MOSI,
  output logic                        MISO,
  input  logic [NUM_CHNL*VAL_W-1:0]   ana_vals,
  output logic [CHNL_W-1:0]           chnl,
  output logic                        cmd_rdy,
  output logic                        err
);
  logic                   w_sclk_rise, w_sclk_fall;
  logic                   w_ss_rise, w_ss_fall;
  logic                   r_mosi_s1, r_mosi_s2;
  a2d_state_e             r_state;
  logic [4:0]             r_bit_cnt;
  logic [FRAME_BITS-1:0]  r_rx_shft;
  logic [FRAME_BITS-1:0]  r_tx_shft;
  logic [CHNL_W-1:0]      r_chnl;
  logic                   r_cmd_rdy, r_err;
  logic [VAL_W-1:0]       w_sel_val;

  spi_sync_edge u_sclk_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SCLK),
    .o_rise (w_sclk_rise),
    .o_fall (w_sclk_fall)
  );

  spi_sync_edge u_ss_sync (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_async(SS_n),
    .o_rise (w_ss_rise),
    .o_fall (w_ss_fall)
  );

  // Two-flop synchronizer for MOSI; it settles well before the SCLK rise is seen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mosi_s1 <= 1'b1;
      r_mosi_s2 <= 1'b1;
    end else begin
      r_mosi_s1 <= MOSI;
      r_mosi_s2 <= r_mosi_s1;
    end
  end

  // Channel value addressed by the last accepted command.
  assign w_sel_val = ana_vals[VAL_W*r_chnl +: VAL_W];

  // Frame FSM: receive command bits, decode on SS_n rise, pulse cmd_rdy/err.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state   <= IDLE;
      r_bit_cnt <= '0;
      r_rx_shft <= '0;
      r_chnl    <= '0;
      r_cmd_rdy <= 1'b0;
      r_err     <= 1'b0;
    end else begin
      r_cmd_rdy <= 1'b0;
      r_err     <= 1'b0;
      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_state   <= SHIFT;
            r_bit_cnt <= '0;
          end
        end
        SHIFT: begin
          if (w_ss_rise) begin
            // Short frame: drop it and keep the old channel.
            r_state <= IDLE;
            r_err   <= 1'b1;
          end else if (w_sclk_rise) begin
            r_rx_shft <= {r_rx_shft[FRAME_BITS-2:0], r_mosi_s2};
            r_bit_cnt <= r_bit_cnt + 5'd1;
            if (r_bit_cnt == 5'(FRAME_BITS - 1)) r_state <= FULL;
          end
        end
        FULL: begin
          // Extra SCLK edges are ignored here; only SS_n rise matters.
          if (w_ss_rise) begin
            r_state <= IDLE;
            if (r_rx_shft[15:14] == 2'b00) begin
              r_chnl    <= r_rx_shft[13:11];
              r_cmd_rdy <= 1'b1;
            end else begin
              r_err <= 1'b1;
            end
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Response shifter: snapshot the channel on SS_n fall, shift on SCLK fall
  // except the leading fall so bit 15 is presented at the first rise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_shft <= '0;
    end else if (w_ss_fall) begin
      r_tx_shft <= {4'h0, w_sel_val};
    end else if (r_state == SHIFT && w_sclk_fall && r_bit_cnt != 5'd0) begin
      r_tx_shft <= {r_tx_shft[FRAME_BITS-2:0], 1'b0};
    end
  end

  assign MISO    = r_tx_shft[FRAME_BITS-1];
  assign chnl    = r_chnl;
  assign cmd_rdy = r_cmd_rdy;
  assign err     = r_err;
endmodule
